vga_pixel_pipe: RTL and testbench

- Downstream consumer of the horizontal/vertical pixel counters (800 x 525 frame, counters wrap at UPPER-1).
- Decodes the counter values into hsync, vsync and blank.
- Issues framebuffer read addresses and aligns the returned pixel data with the sync outputs through a 2-stage pipeline.
- Output feeds the VGA DAC pins directly.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_pixel_pipe_if.sv | 17 +
 rtl/vga_sync_decode.sv | 31 +++
 rtl/vga_pixel_pipe.sv | 128 ++++++++++++
 tb/tb_vga_pixel_pipe.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Default 640x480@60 timing constants shared by the pixel pipeline,
//   their derived totals and sync window bounds, the counter type, and
//   the stage-1 decode record.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // Sync windows are [START, END).
   localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
   localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

   localparam int CNT_W = 11;
   typedef logic [CNT_W-1:0] cnt_t;

   // Stage-1 decode of one counter pair.
   typedef struct packed {
      logic act;  // inside the visible area
      logic hs;   // horizontal sync window (level-free flag)
      logic vs;   // vertical sync window (level-free flag)
      logic sof;  // counters at (0,0)
   } stage1_t;

endpackage

// File: rtl/vga_pixel_pipe_if.sv
// vga_pixel_pipe_if
//   Framebuffer read bus between the pixel pipeline (master) and the
//   framebuffer (slave).
//   rd_en   : read request, level; may stay high across idle clocks
//   rd_addr : pixel address y*H_ACTIVE + x
//   rd_data : pixel data, valid by the next pixel strobe after rd_en
interface vga_pixel_pipe_if #(
   parameter int ADDR_W = 19,
   parameter int PIX_W  = 8
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [PIX_W-1:0]  rd_data;

   modport master (output rd_en, output rd_addr, input rd_data);
   modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/vga_sync_decode.sv
// vga_sync_decode
//   Combinational stage-1 compare logic for one counter axis.
//   cnt    : counter value (11-bit unsigned)
//   act    : cnt < ACTIVE
//   sync   : SYNC_START <= cnt < SYNC_END
//   in_rng : cnt < TOTAL
//   zero   : cnt == 0
module vga_sync_decode
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE     = DEF_H_ACTIVE,
   parameter int SYNC_START = DEF_HS_START,
   parameter int SYNC_END   = DEF_HS_END,
   parameter int TOTAL      = DEF_H_TOTAL
) (
   input  cnt_t cnt,
   output logic act,
   output logic sync,
   output logic in_rng,
   output logic zero
);
   localparam cnt_t C_ACT = CNT_W'(ACTIVE);
   localparam cnt_t C_SS  = CNT_W'(SYNC_START);
   localparam cnt_t C_SE  = CNT_W'(SYNC_END);
   localparam cnt_t C_TOT = CNT_W'(TOTAL);

   assign act    = cnt < C_ACT;
   assign sync   = (cnt >= C_SS) && (cnt < C_SE);
   assign in_rng = cnt < C_TOT;
   assign zero   = cnt == '0;
endmodule

// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe
//   Decodes the pixel counters into hsync/vsync/blank, issues framebuffer
//   reads and aligns the returned pixel with the syncs. Every output is
//   2 pixel strobes behind the counter value that produced it.
//   clk, reset(async, active low), pix_en (pipeline advance strobe)
//   hcnt, vcnt   : counter values, 11-bit
//   fb           : framebuffer read bus (master side)
//   hsync, vsync : sync pins at SYNC_ACT polarity
//   blank        : high outside the visible area
//   pix_out      : pixel to the DAC, 0 while blanked
//   frame_start  : one-clk pulse with pixel (0,0) on the outputs
module vga_pixel_pipe
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_ACT = 1'b0,
   parameter int   ADDR_W   = 19,
   parameter int   PIX_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_en,
   input  cnt_t              hcnt,
   input  cnt_t              vcnt,
   vga_pixel_pipe_if.master  fb,
   output logic              hsync,
   output logic              vsync,
   output logic              blank,
   output logic [PIX_W-1:0]  pix_out,
   output logic              frame_start
);
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   if (longint'(H_ACTIVE) * longint'(V_ACTIVE) > (longint'(1) << ADDR_W)) begin : g_addr_chk
      $error("vga_pixel_pipe: visible area does not fit in ADDR_W");
   end
   if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_cnt_chk
      $error("vga_pixel_pipe: frame does not fit in the 11-bit counters");
   end

   // ---------------- stage 1 decode ----------------
   logic h_act, h_sync, h_rng, h_zero;
   logic v_act, v_sync, v_rng, v_zero;

   vga_sync_decode #(
      .ACTIVE(H_ACTIVE), .SYNC_START(HS_START),
      .SYNC_END(HS_START + H_SYNC), .TOTAL(H_TOTAL)
   ) u_hdec (.cnt(hcnt), .act(h_act), .sync(h_sync), .in_rng(h_rng), .zero(h_zero));

   vga_sync_decode #(
      .ACTIVE(V_ACTIVE), .SYNC_START(VS_START),
      .SYNC_END(VS_START + V_SYNC), .TOTAL(V_TOTAL)
   ) u_vdec (.cnt(vcnt), .act(v_act), .sync(v_sync), .in_rng(v_rng), .zero(v_zero));

   stage1_t s1_d, s1;
   logic    in_rng;

   // A sync window on one axis must not fire while the other axis is
   // outside the frame.
   assign in_rng   = h_rng & v_rng;
   assign s1_d.act = h_act & v_act;
   assign s1_d.hs  = h_sync & in_rng;
   assign s1_d.vs  = v_sync & in_rng;
   assign s1_d.sof = h_zero & v_zero;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      s1 <= '0;
      else if (pix_en) s1 <= s1_d;
   end

   assign fb.rd_en = s1.act;

   // ---------------- address counter ----------------
   // addr is the address presented with the current stage-1 pixel; nxt is
   // the address the next visible pixel will use. Only (0,0) restarts the
   // sequence; nxt saturates at the last pixel instead of wrapping.
   logic [ADDR_W-1:0] addr, nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr <= '0;
         nxt  <= '0;
      end else if (pix_en) begin
         if (s1_d.sof) begin
            addr <= '0;
            nxt  <= ADDR_W'(1);
         end else if (s1_d.act) begin
            addr <= nxt;
            if (nxt != LAST_ADDR) nxt <= nxt + ADDR_W'(1);
         end
      end
   end

   assign fb.rd_addr = addr;

   // ---------------- stage 2 / output pins ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hsync       <= ~SYNC_ACT;
         vsync       <= ~SYNC_ACT;
         blank       <= 1'b1;
         pix_out     <= '0;
         frame_start <= 1'b0;
      end else begin
         // Sampled every clk so the pulse drops after one clk even when
         // pix_en stays low and s1.sof is held.
         frame_start <= pix_en & s1.sof;
         if (pix_en) begin
            hsync   <= s1.hs ? SYNC_ACT : ~SYNC_ACT;
            vsync   <= s1.vs ? SYNC_ACT : ~SYNC_ACT;
            blank   <= ~s1.act;
            pix_out <= s1.act ? fb.rd_data : '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
`timescale 1ns/1ps
module tb_vga_pixel_pipe;
   import vga_timing_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       pix_en, pix_en2;
   cnt_t       hcnt, vcnt, hcnt2, vcnt2;
   logic       hsync, vsync, blank, frame_start;
   logic [7:0] pix_out;
   logic       hsync2, vsync2, blank2, frame_start2;
   logic [7:0] pix_out2;

   // Default-timing DUT; framebuffer returns the low byte of the address.
   vga_pixel_pipe_if #(.ADDR_W(19), .PIX_W(8)) fb ();
   assign fb.rd_data = fb.rd_addr[7:0];

   vga_pixel_pipe dut (
      .clk(clk), .reset(reset), .pix_en(pix_en), .hcnt(hcnt), .vcnt(vcnt),
      .fb(fb), .hsync(hsync), .vsync(vsync), .blank(blank),
      .pix_out(pix_out), .frame_start(frame_start)
   );

   // Tiny-timing DUT (20x6 visible, 29x10 total) so whole frames are cheap.
   vga_pixel_pipe_if #(.ADDR_W(7), .PIX_W(8)) fb2 ();
   assign fb2.rd_data = 8'(fb2.rd_addr);

   vga_pixel_pipe #(
      .H_ACTIVE(20), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_ACT(1'b0), .ADDR_W(7), .PIX_W(8)
   ) dut2 (
      .clk(clk), .reset(reset), .pix_en(pix_en2), .hcnt(hcnt2), .vcnt(vcnt2),
      .fb(fb2), .hsync(hsync2), .vsync(vsync2), .blank(blank2),
      .pix_out(pix_out2), .frame_start(frame_start2)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (default timing) ----------------
   localparam int LAST = 640 * 480 - 1;

   function automatic bit f_rng(int h, int v); return h < 800 && v < 525; endfunction
   function automatic bit f_act(int h, int v); return h < 640 && v < 480; endfunction
   function automatic bit f_hs(int h, int v);  return f_rng(h, v) && h >= 656 && h < 752; endfunction
   function automatic bit f_vs(int h, int v);  return f_rng(h, v) && v >= 490 && v < 492; endfunction

   int ph, pv;     // counter taken at the latest strobe (stage 1)
   int sh, sv;     // counter taken one strobe earlier (on the pins)
   int m_addr;     // expected rd_addr
   int m_n;        // address the next visible pixel reads
   int m_pix;      // framebuffer byte captured with the pin pixel
   bit m_fs;

   task automatic model_reset();
      ph = 2047; pv = 2047; sh = 2047; sv = 2047;
      m_addr = 0; m_n = 0; m_pix = 0; m_fs = 0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_hsync"}, 32'(hsync), 1);
      chk({tag, "_vsync"}, 32'(vsync), 1);
      chk({tag, "_blank"}, 32'(blank), 1);
      chk({tag, "_pix"},   32'(pix_out), 0);
      chk({tag, "_rd_en"}, 32'(fb.rd_en), 0);
      chk({tag, "_addr"},  32'(fb.rd_addr), 0);
      chk({tag, "_fs"},    32'(frame_start), 0);
   endtask

   // One clk: drive counters and strobe, advance the model, compare all pins.
   task automatic cyc(input int h, input int v, input bit pe);
      hcnt = 11'(h); vcnt = 11'(v); pix_en = pe;
      @(posedge clk); #1;
      if (pe) begin
         sh = ph; sv = pv;
         m_pix = m_addr & 255;
         m_fs  = (sh == 0 && sv == 0);
         ph = h; pv = v;
         if (h == 0 && v == 0) begin
            m_addr = 0; m_n = 1;
         end else if (f_act(h, v)) begin
            m_addr = m_n;
            if (m_n < LAST) m_n++;
         end
      end else begin
         m_fs = 0;
      end
      chk("hsync",       32'(hsync),       f_hs(sh, sv) ? 0 : 1);
      chk("vsync",       32'(vsync),       f_vs(sh, sv) ? 0 : 1);
      chk("blank",       32'(blank),       f_act(sh, sv) ? 0 : 1);
      chk("pix_out",     32'(pix_out),     f_act(sh, sv) ? m_pix : 0);
      chk("rd_en",       32'(fb.rd_en),    32'(f_act(ph, pv)));
      chk("rd_addr",     32'(fb.rd_addr),  m_addr);
      chk("frame_start", 32'(frame_start), 32'(m_fs));
   endtask

   typedef struct {
      int h; int v;
      bit hs_n; bit vs_n; bit bl; bit re;
   } vec_t;
   vec_t tbl[13];

   initial begin
      int hs_low, bl_low, first_hs, vs_low, fs_clks, k, a_before;
      int vs2, hs2, bl2, amax;

      tbl[0]  = '{810, 530, 1, 1, 1, 0};
      tbl[1]  = '{656,   0, 0, 1, 1, 0};
      tbl[2]  = '{751,  10, 0, 1, 1, 0};
      tbl[3]  = '{752,  10, 1, 1, 1, 0};
      tbl[4]  = '{655,  10, 1, 1, 1, 0};
      tbl[5]  = '{700, 490, 0, 0, 1, 0};
      tbl[6]  = '{100, 491, 1, 0, 1, 0};
      tbl[7]  = '{100, 492, 1, 1, 1, 0};
      tbl[8]  = '{639, 479, 1, 1, 0, 1};
      tbl[9]  = '{640, 479, 1, 1, 1, 0};
      tbl[10] = '{  0, 480, 1, 1, 1, 0};
      tbl[11] = '{700, 530, 1, 1, 1, 0};
      tbl[12] = '{900, 100, 1, 1, 1, 0};

      pix_en2 = 1'b0; hcnt2 = '0; vcnt2 = '0;
      reset = 1'b0; pix_en = 1'b1; hcnt = 11'd300; vcnt = 11'd100;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("por");

      // Run mid-line, then hit reset asynchronously at (300,100).
      reset = 1'b1;
      for (int h = 290; h < 300; h++) cyc(h, 100, 1);
      hcnt = 11'd300;
      reset = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("held_rst");
      reset = 1'b1;
      model_reset();

      // Line 0 from (0,0).
      hs_low = 0; bl_low = 0; first_hs = -1;
      for (int h = 0; h < 800; h++) begin
         cyc(h, 0, 1);
         if (hsync == 1'b0) begin
            hs_low++;
            if (first_hs < 0) first_hs = h;
         end
         if (blank == 1'b0) bl_low++;
         if (h <= 2) chk("fs_after_release", 32'(frame_start), 32'(h == 1));
         if (h < 640) chk("rd_addr_line0", 32'(fb.rd_addr), 32'(h));
      end
      chk("hsync_low_len",   32'(hs_low),   96);
      chk("hsync_first",     32'(first_hs), 657);
      chk("blank_low_len",   32'(bl_low),   640);

      // Line 1: pixel values through the framebuffer.
      for (int h = 0; h < 800; h++) begin
         cyc(h, 1, 1);
         if (h == 6)   chk("pix_x5_y1",  32'(pix_out), 133);
         if (h == 701) chk("pix_h700",   32'(pix_out), 0);
      end

      // Vertical sync region.
      vs_low = 0;
      for (int v = 488; v < 494; v++) begin
         cyc(0, v, 1);   cyc(100, v, 1);
         cyc(660, v, 1); cyc(799, v, 1);
         if (vsync == 1'b0) vs_low++;
      end
      chk("vsync_lines", 32'(vs_low), 2);

      // Decode table: each vector held for two strobes.
      foreach (tbl[i]) begin
         a_before = m_addr;
         cyc(tbl[i].h, tbl[i].v, 1);
         cyc(tbl[i].h, tbl[i].v, 1);
         chk("tbl_hsync", 32'(hsync),    32'(tbl[i].hs_n));
         chk("tbl_vsync", 32'(vsync),    32'(tbl[i].vs_n));
         chk("tbl_blank", 32'(blank),    32'(tbl[i].bl));
         chk("tbl_rd_en", 32'(fb.rd_en), 32'(tbl[i].re));
         if (!tbl[i].re) chk("tbl_addr_hold", 32'(fb.rd_addr), 32'(a_before));
      end

      // Strobe one clk in four; counters scrambled between strobes.
      fs_clks = 0; k = 0;
      for (int i = 0; i < 160; i++) begin
         if (i % 4 == 0) begin
            cyc(k, 0, 1);
            k++;
         end else begin
            cyc(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), 0);
         end
         if (frame_start) fs_clks++;
      end
      chk("fs_width_sparse", 32'(fs_clks), 1);

      // Random counters and strobes.
      for (int i = 0; i < 800; i++) begin
         int h, v;
         case ($urandom_range(0, 4))
            0:       begin h = int'($urandom_range(0, 3)); v = 0; end
            1:       begin h = int'($urandom_range(640, 760)); v = int'($urandom_range(470, 500)); end
            default: begin h = int'($urandom_range(0, 850)); v = int'($urandom_range(0, 540)); end
         endcase
         cyc(h, v, $urandom_range(0, 2) != 0);
      end
      pix_en = 1'b0;

      // Small-timing DUT: two whole frames.
      pix_en2 = 1'b1;
      vs2 = 0; hs2 = 0; bl2 = 0; amax = 0;
      for (int f = 0; f < 2; f++) begin
         for (int v = 0; v < 10; v++) begin
            for (int h = 0; h < 29; h++) begin
               hcnt2 = 11'(h); vcnt2 = 11'(v);
               @(posedge clk); #1;
               if (!vsync2) vs2++;
               if (!hsync2) hs2++;
               if (!blank2) bl2++;
               if (fb2.rd_en && int'(fb2.rd_addr) > amax) amax = int'(fb2.rd_addr);
               if (v == 0 && h == 0) chk("small_addr_sof", 32'(fb2.rd_addr), 0);
               if (v == 9 && h == 28) chk("small_addr_end", 32'(fb2.rd_addr), 119);
               if (f == 1 && v == 1 && h == 6) chk("small_pix_x5_y1", 32'(pix_out2), 25);
               if (f == 1 && v == 0 && h == 1) chk("small_fs", 32'(frame_start2), 1);
            end
         end
      end
      chk("small_vsync_cnt", 32'(vs2), 116);
      chk("small_hsync_cnt", 32'(hs2), 80);
      chk("small_blank_cnt", 32'(bl2), 240);
      chk("small_addr_max",  32'(amax), 119);
      // A visible pixel without a new (0,0): address stays saturated.
      hcnt2 = 11'd3; vcnt2 = 11'd2;
      @(posedge clk); #1;
      chk("small_addr_sat", 32'(fb2.rd_addr), 119);
      pix_en2 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
